// File: rtl/dme_pulse_pair_gen.sv
// DME interrogator pulse-pair generator: timing FSM, carrier ROM gating, envelope multiply.
// Define DME_ROUND_EN to round-and-saturate the output instead of truncating.
module dme_pulse_pair_gen #(
  parameter int CNT_W     = 32,
  parameter int ENV_W     = 12,
  parameter int CARR_W    = 12,
  parameter int OUT_W     = 16,
  parameter int ROM_DEPTH = 5000,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  T1,
  input  logic [CNT_W-1:0]  T2,
  input  logic [CNT_W-1:0]  T3,
  input  logic [ENV_W-1:0]  env,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CARR_W-1:0] rom_data,
  output logic              ena,
  output logic              pulse_idx,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              cfg_err
);

  localparam int PROD_W = ENV_W + CARR_W;
  localparam int SHIFT  = PROD_W - OUT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_GAP,
    S_P2,
    S_REST
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  t1_q, t1_d;
  logic [CNT_W-1:0]  t2_q, t2_d;
  logic [CNT_W-1:0]  t3_q, t3_d;
  logic [1:0]        mode_q, mode_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_q, ena_d;
  logic              pidx_q, pidx_d;
  logic              ena_d1_q, ena_d1_d;
  logic              valid_q, valid_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              err_q, err_d;

  logic [CNT_W:0]    sum_in;
  logic [CNT_W-1:0]  end2;
  logic              pair_in;
  logic              cfg_ok;
  logic              stop_now;

  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         red;

  always_comb begin
    sum_in  = {1'b0, T2} + {1'b0, T1};
    pair_in = (mode != 2'd2);
    cfg_ok  = (T1 != '0) && (T3 > T1) &&
              (!pair_in || ((T2 > T1) && ({1'b0, T3} > sum_in)));
  end

  assign end2     = t2_q + t1_q;
  assign stop_now = stop_q | stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    err_d   = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (stop) stop_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = S_P1;
            cnt_d   = CNT_W'(1);
            t1_d    = T1;
            t2_d    = T2;
            t3_d    = T3;
            mode_d  = (mode == 2'd3) ? 2'd0 : mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_P1: begin
        if (cnt_q == t1_q)
          state_d = (mode_q == 2'd2) ? S_REST : S_GAP;
      end
      S_GAP: begin
        if (cnt_q == t2_q) state_d = S_P2;
      end
      S_P2: begin
        if (cnt_q == end2)
          state_d = (mode_q == 2'd0) ? S_IDLE : S_REST;
      end
      S_REST: begin
        if (cnt_q == t3_q) begin
          if (stop_now) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_P1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) stop_d = 1'b0;
  end

  // Address restarts at every pulse-1 entry and keeps counting into pulse 2.
  always_comb begin
    ena_d  = (state_d == S_P1) || (state_d == S_P2);
    pidx_d = (state_d == S_P2);
    addr_d = addr_q;
    if ((state_d == S_P1) && (state_q != S_P1)) begin
      addr_d = '0;
    end else if (ena_q) begin
      if (addr_q == ADDR_W'(ROM_DEPTH - 1)) addr_d = '0;
      else addr_d = addr_q + ADDR_W'(1);
    end
  end

  assign prod = $signed(env) * $signed(rom_data);

`ifdef DME_ROUND_EN
  logic signed [PROD_W:0] rsum;
  logic [OUT_W:0]         rtop;
  always_comb begin
    rsum = {prod[PROD_W-1], prod} + ((PROD_W+1)'(1) << (SHIFT - 1));
    rtop = (OUT_W+1)'(rsum >>> SHIFT);
    if (rtop[OUT_W] != rtop[OUT_W-1])
      red = {1'b0, {(OUT_W-1){1'b1}}};
    else
      red = rtop[OUT_W-1:0];
  end
`else
  assign red = OUT_W'(prod >>> SHIFT);
`endif

  always_comb begin
    ena_d1_d = ena_q;
    valid_d  = ena_d1_q;
    out_d    = ena_d1_q ? red : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      t3_q     <= '0;
      mode_q   <= 2'd0;
      stop_q   <= 1'b0;
      addr_q   <= '0;
      ena_q    <= 1'b0;
      pidx_q   <= 1'b0;
      ena_d1_q <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      t3_q     <= t3_d;
      mode_q   <= mode_d;
      stop_q   <= stop_d;
      addr_q   <= addr_d;
      ena_q    <= ena_d;
      pidx_q   <= pidx_d;
      ena_d1_q <= ena_d1_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign rom_en    = ena_q;
  assign ena       = ena_q;
  assign rom_addr  = addr_q;
  assign pulse_idx = pidx_q;
  assign out_data  = out_q;
  assign out_valid = valid_q;
  assign cfg_err   = err_q;
  assign busy      = (state_q != S_IDLE) | ena_d1_q | valid_q;

endmodule

// File: tb/tb_dme_pulse_pair_gen.sv
// Bench for dme_pulse_pair_gen: timing model per cycle plus a
// scoreboard of expected modulated samples fed by a behavioural ROM.
module tb_dme_pulse_pair_gen;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [31:0] T1, T2, T3;
  logic [11:0] env;
  logic [11:0] rom_data;
  logic        rom_en;
  logic [12:0] rom_addr;
  logic        ena;
  logic        pulse_idx;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        cfg_err;

  int total  = 0;
  int passed = 0;
  int sb[$];

  int cm, c1, c2, c3, cstop;
  bit rom_fix = 1'b0;
  bit en_s = 1'b0;
  logic [12:0] addr_s = '0;

  dme_pulse_pair_gen #(
    .CNT_W(32), .ENV_W(12), .CARR_W(12), .OUT_W(16),
    .ROM_DEPTH(DEPTH), .ADDR_W(13)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .mode(mode), .T1(T1), .T2(T2), .T3(T3), .env(env),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .ena(ena), .pulse_idx(pulse_idx), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic signed [11:0] rom_fn(input int a);
    if (rom_fix) return 12'sd16;
    return 12'(a * 500 - 1800);
  endfunction

  function automatic int model(input int rd, input int ev);
    longint p, r;
    p = longint'(rd) * longint'(ev);
`ifdef DME_ROUND_EN
    p = p + 128;
`endif
    r = p >>> 8;
    if (r > 32767) r = 32767;
    return int'(r);
  endfunction

  function automatic int plast();
    if (cm == 0) return 0;
    return (cstop - 1) / c3;
  endfunction

  function automatic bit f_ena(input int k);
    int p, o;
    if (k < 1) return 1'b0;
    p = (k - 1) / c3;
    o = (k - 1) % c3 + 1;
    if (p > plast()) return 1'b0;
    if (o <= c1) return 1'b1;
    return (cm != 2) && (o > c2) && (o <= c2 + c1);
  endfunction

  function automatic bit f_pidx(input int k);
    int p, o;
    if (k < 1) return 1'b0;
    p = (k - 1) / c3;
    o = (k - 1) % c3 + 1;
    if (p > plast()) return 1'b0;
    return (cm != 2) && (o > c2) && (o <= c2 + c1);
  endfunction

  function automatic int f_send();
    if (cm == 0) return c2 + c1;
    return (plast() + 1) * c3;
  endfunction

  function automatic bit f_busy(input int k);
    int le, se;
    se = f_send();
    le = (cm == 0) ? c2 + c1 : plast() * c3 + ((cm == 2) ? c1 : c2 + c1);
    if (le + 2 > se) se = le + 2;
    return (k >= 1) && (k <= se);
  endfunction

  function automatic int f_addr(input int k);
    int o, n;
    o = (k - 1) % c3 + 1;
    if (o <= c1) n = o - 1;
    else if (cm == 2 || o <= c2) n = c1;
    else if (o <= c2 + c1) n = c1 + (o - c2 - 1);
    else n = 2 * c1;
    return n % DEPTH;
  endfunction

  // ROM with one-cycle latency and an envelope aligned to its data.
  always @(posedge clk) begin : rom_blk
    logic signed [11:0] rd, ev;
    if (resetn && en_s) begin
      rd = rom_fn(int'(addr_s));
      ev = rom_fix ? 12'sd12 : 12'($urandom);
      rom_data <= rd;
      env      <= ev;
      sb.push_back(model(int'(rd), int'(ev)));
    end else begin
      rom_data <= 12'($urandom);
      env      <= 12'($urandom);
    end
  end

  always @(negedge clk) begin : mon_blk
    int e;
    en_s   = rom_en;
    addr_s = rom_addr;
    if (resetn) begin
      total++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected out_data=%0d with no pending sample", $signed(out_data));
        end else begin
          e = sb.pop_front();
          if (out_data !== 16'(e))
            $display("FAIL sb_data got=%0d exp=%0d", $signed(out_data), e);
          else passed++;
        end
      end else begin
        if (out_data !== 16'd0)
          $display("FAIL idle_zero got=%0d exp=0", $signed(out_data));
        else passed++;
      end
    end
  end

  task automatic kick(input int m, input int t1, input int t2, input int t3, input int sk);
    cm = (m == 3) ? 0 : m;
    c1 = t1; c2 = t2; c3 = t3; cstop = sk;
    @(negedge clk);
    mode = 2'(m); T1 = t1; T2 = t2; T3 = t3;
    start = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    T1 = '0; T2 = '0; T3 = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ena, rom_en, rom_addr, pulse_idx, out_data, out_valid, busy, cfg_err} !== '0)
      $display("FAIL reset_outs got=%0h exp=0",
               {ena, rom_en, rom_addr, pulse_idx, out_data, out_valid, busy, cfg_err});
    else passed++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ena, busy, cfg_err, rom_addr} !== '0)
      $display("FAIL post_reset got=%0h exp=0", {ena, busy, cfg_err, rom_addr});
    else passed++;
  endtask

  task automatic test_oneshot_pair;
    kick(0, 4, 10, 30, 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; mode = 2'd2; T1 = 1; T2 = 2; T3 = 3;
      end
      total++;
      if (ena !== f_ena(k)) $display("FAIL os_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
      total++;
      if (pulse_idx !== f_pidx(k)) $display("FAIL os_pidx cyc=%0d got=%b exp=%b", k, pulse_idx, f_pidx(k));
      else passed++;
      total++;
      if (out_valid !== f_ena(k - 2)) $display("FAIL os_valid cyc=%0d got=%b exp=%b", k, out_valid, f_ena(k - 2));
      else passed++;
      total++;
      if (busy !== f_busy(k)) $display("FAIL os_busy cyc=%0d got=%b exp=%b", k, busy, f_busy(k));
      else passed++;
      if (k <= f_send()) begin
        total++;
        if (rom_addr !== 13'(f_addr(k))) $display("FAIL os_addr cyc=%0d got=%0d exp=%0d", k, rom_addr, f_addr(k));
        else passed++;
      end
    end
  endtask

  task automatic test_single_wrap;
    kick(2, 20, 0, 40, 45);
    for (int k = 1; k <= 85; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      stop = (k == 45);
      total++;
      if ({ena, rom_en} !== {2{f_ena(k)}}) $display("FAIL sp_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
      total++;
      if (pulse_idx !== 1'b0) $display("FAIL sp_pidx cyc=%0d got=%b exp=0", k, pulse_idx);
      else passed++;
      total++;
      if (busy !== f_busy(k)) $display("FAIL sp_busy cyc=%0d got=%b exp=%b", k, busy, f_busy(k));
      else passed++;
      if (k <= f_send()) begin
        total++;
        if (rom_addr !== 13'(f_addr(k))) $display("FAIL sp_addr cyc=%0d got=%0d exp=%0d", k, rom_addr, f_addr(k));
        else passed++;
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_continuous_stop;
    kick(1, 2, 5, 12, 15);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      start = (k == 5);
      stop = (k == 15);
      total++;
      if (ena !== f_ena(k)) $display("FAIL cp_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
      total++;
      if (pulse_idx !== f_pidx(k)) $display("FAIL cp_pidx cyc=%0d got=%b exp=%b", k, pulse_idx, f_pidx(k));
      else passed++;
      total++;
      if (out_valid !== f_ena(k - 2)) $display("FAIL cp_valid cyc=%0d got=%b exp=%b", k, out_valid, f_ena(k - 2));
      else passed++;
      total++;
      if (busy !== f_busy(k)) $display("FAIL cp_busy cyc=%0d got=%b exp=%b", k, busy, f_busy(k));
      else passed++;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_cfg_err;
    kick(0, 4, 3, 30, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (cfg_err !== (k == 1)) $display("FAIL ce_flag cyc=%0d got=%b exp=%b", k, cfg_err, k == 1);
      else passed++;
      total++;
      if ({ena, busy} !== 2'b00) $display("FAIL ce_idle cyc=%0d got=%b exp=00", k, {ena, busy});
      else passed++;
    end
    kick(3, 2, 4, 10, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (cfg_err !== 1'b0) $display("FAIL ce_ok_flag cyc=%0d got=%b exp=0", k, cfg_err);
      else passed++;
      total++;
      if (ena !== f_ena(k)) $display("FAIL ce_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
      total++;
      if (busy !== f_busy(k)) $display("FAIL ce_busy cyc=%0d got=%b exp=%b", k, busy, f_busy(k));
      else passed++;
    end
  endtask

  task automatic test_reset_abort;
    kick(0, 4, 10, 30, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (ena !== f_ena(k)) $display("FAIL ra_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
    end
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({ena, rom_en, rom_addr, pulse_idx, out_data, out_valid, busy, cfg_err} !== '0)
      $display("FAIL ra_outs got=%0h exp=0",
               {ena, rom_en, rom_addr, pulse_idx, out_data, out_valid, busy, cfg_err});
    else passed++;
    repeat (2) @(negedge clk);
    sb.delete();
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL ra_quiet got=%b exp=00", {out_valid, busy});
    else passed++;
    kick(0, 4, 10, 30, 0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (ena !== f_ena(k)) $display("FAIL ra2_ena cyc=%0d got=%b exp=%b", k, ena, f_ena(k));
      else passed++;
      if (k <= f_send()) begin
        total++;
        if (rom_addr !== 13'(f_addr(k))) $display("FAIL ra2_addr cyc=%0d got=%0d exp=%0d", k, rom_addr, f_addr(k));
        else passed++;
      end
    end
  endtask

  task automatic test_rounding;
    logic [15:0] exp_v;
`ifdef DME_ROUND_EN
    exp_v = 16'd1;
`else
    exp_v = 16'd0;
`endif
    rom_fix = 1'b1;
    kick(0, 2, 4, 10, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (out_valid !== f_ena(k - 2)) $display("FAIL rd_valid cyc=%0d got=%b exp=%b", k, out_valid, f_ena(k - 2));
      else passed++;
      if (f_ena(k - 2)) begin
        total++;
        if (out_data !== exp_v) $display("FAIL rd_data cyc=%0d got=%0d exp=%0d", k, out_data, exp_v);
        else passed++;
      end
    end
    rom_fix = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot_pair();
    test_single_wrap();
    test_continuous_stop();
    test_cfg_err();
    test_reset_abort();
    test_rounding();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
